// File: rtl/reaction_pkg.sv
// Shared constants, state codes and helpers for the reaction-time measurement block.
package reaction_pkg;

   localparam int MS_W  = 14;
   localparam int BCD_W = 16;

   localparam logic [3:0] ST_WAIT    = 4'd1;
   localparam logic [3:0] ST_MEASURE = 4'd2;
   localparam logic [3:0] ST_RESULT  = 4'd3;

   typedef enum logic [1:0] {
      S_IDLE,
      S_COUNT,
      S_CONVERT,
      S_HOLD
   } measState_t;

   // Double-dabble correction: any digit of 5 or more gets +3 before the next shift.
   function automatic logic [BCD_W-1:0] add3Digits(input logic [BCD_W-1:0] bcdIn);
      logic [BCD_W-1:0] res;
      res = bcdIn;
      for (int i = 0; i < BCD_W/4; i++) begin
         if (res[i*4 +: 4] >= 4'd5) begin
            res[i*4 +: 4] = res[i*4 +: 4] + 4'd3;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: start is sampled, then one bit is shifted per
// cycle; done pulses together with the refreshed bcd result 15 cycles after start.
module bin2bcd_seq
   import reaction_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic             i_abort,
   input  logic [MS_W-1:0]  i_bin,
   output logic             o_busy,
   output logic             o_done,
   output logic [BCD_W-1:0] o_bcd
);

   localparam logic [3:0] SHIFTS = 4'(MS_W);

   logic [BCD_W-1:0] r_acc;
   logic [MS_W-1:0]  r_bin;
   logic [3:0]       r_cnt;
   logic             r_busy;
   logic             r_done;
   logic [BCD_W-1:0] r_bcd;
   logic [BCD_W-1:0] w_adj;
   logic [BCD_W-1:0] w_shifted;

   assign w_adj     = add3Digits(r_acc);
   assign w_shifted = {w_adj[BCD_W-2:0], r_bin[MS_W-1]};

   // An aborted conversion never touches the published result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc  <= '0;
         r_bin  <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_bcd  <= '0;
      end else begin
         r_done <= 1'b0;
         if (i_abort) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
         end else if (i_start) begin
            r_acc  <= '0;
            r_bin  <= i_bin;
            r_cnt  <= SHIFTS;
            r_busy <= 1'b1;
         end else if (r_busy) begin
            r_acc <= w_shifted;
            r_bin <= {r_bin[MS_W-2:0], 1'b0};
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
               r_bcd  <= w_shifted;
               r_done <= 1'b1;
               r_busy <= 1'b0;
            end
         end
      end
   end

   assign o_busy = r_busy;
   assign o_done = r_done;
   assign o_bcd  = r_bcd;

endmodule

// File: rtl/reaction_measure.sv
// Reaction-time measurement: counts ms ticks from "go" until KEY[1] is pressed,
// converts the result to BCD and keeps the best valid time since reset.
module reaction_measure
   import reaction_pkg::*;
#(
   parameter int CLK_HZ  = 50_000_000,
   parameter int TICK_HZ = 1000,
   parameter int MAX_MS  = 9999
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [1:0]       KEY,
   output logic             go_led,
   output logic [MS_W-1:0]  elapsed_ms,
   output logic [MS_W-1:0]  best_ms,
   output logic [BCD_W-1:0] bcd,
   output logic             bcd_valid,
   output logic             false_start,
   output logic             timeout,
   output logic [3:0]       out_state
);

   localparam int               DIV       = CLK_HZ / TICK_HZ;
   localparam int               CNT_W     = $clog2(DIV);
   localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(DIV - 1);
   localparam logic [MS_W-1:0]  MAX_V     = MS_W'(MAX_MS);
   localparam logic [MS_W-1:0]  MAX_PREV  = MS_W'(MAX_MS - 1);

   measState_t       r_state;
   logic [2:0]       r_sync;
   logic [CNT_W-1:0] r_tickCnt;
   logic             r_goLed;
   logic [MS_W-1:0]  r_elapsed;
   logic [MS_W-1:0]  r_best;
   logic             r_bcdValid;
   logic             r_falseStart;
   logic             r_timeout;
   logic [3:0]       r_outState;

   logic             w_press;
   logic             w_pressEdge;
   logic             w_tick;
   logic             w_hitMax;
   logic             w_convStart;
   logic             w_convDone;
   logic             w_unusedConvBusy;
   logic             w_unusedKey;
   logic [MS_W-1:0]  w_convBin;
   logic [BCD_W-1:0] w_convBcd;

   assign w_unusedKey = KEY[0];

   // r_sync[1] is the synchronized key, r_sync[2] its previous value for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= 3'b111;
      end else begin
         r_sync <= {r_sync[1:0], KEY[1]};
      end
   end

   assign w_press     = ~r_sync[1];
   assign w_pressEdge = r_sync[2] & ~r_sync[1];
   assign w_tick      = (r_tickCnt == TICK_LAST);
   assign w_hitMax    = w_tick && (r_elapsed == MAX_PREV);

   // The converter starts on the same edge the count freezes, so it is fed the frozen value.
   assign w_convStart = en && (((r_state == S_IDLE) && w_press) ||
                               ((r_state == S_COUNT) && (w_pressEdge || w_hitMax)));

   always_comb begin
      w_convBin = '0;
      if (r_state == S_COUNT) begin
         w_convBin = (!w_pressEdge && w_hitMax) ? MAX_V : r_elapsed;
      end
   end

   bin2bcd_seq u_bin2bcd (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_start (w_convStart),
      .i_abort (~en),
      .i_bin   (w_convBin),
      .o_busy  (w_unusedConvBusy),
      .o_done  (w_convDone),
      .o_bcd   (w_convBcd)
   );

   // Dropping en wins over everything and returns to IDLE with results retained.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_tickCnt    <= '0;
         r_goLed      <= 1'b0;
         r_elapsed    <= '0;
         r_best       <= MAX_V;
         r_bcdValid   <= 1'b0;
         r_falseStart <= 1'b0;
         r_timeout    <= 1'b0;
         r_outState   <= ST_WAIT;
      end else if (!en) begin
         r_state    <= S_IDLE;
         r_goLed    <= 1'b0;
         r_outState <= ST_WAIT;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_elapsed    <= '0;
               r_bcdValid   <= 1'b0;
               r_falseStart <= 1'b0;
               r_timeout    <= 1'b0;
               r_outState   <= ST_MEASURE;
               if (w_press) begin
                  r_falseStart <= 1'b1;
                  r_state      <= S_CONVERT;
               end else begin
                  r_tickCnt <= '0;
                  r_goLed   <= 1'b1;
                  r_state   <= S_COUNT;
               end
            end
            S_COUNT: begin
               r_tickCnt <= w_tick ? '0 : r_tickCnt + 1'b1;
               if (w_pressEdge) begin
                  r_goLed <= 1'b0;
                  r_state <= S_CONVERT;
               end else if (w_hitMax) begin
                  r_elapsed <= MAX_V;
                  r_timeout <= 1'b1;
                  r_goLed   <= 1'b0;
                  r_state   <= S_CONVERT;
               end else if (w_tick) begin
                  r_elapsed <= r_elapsed + 1'b1;
               end
            end
            S_CONVERT: begin
               if (w_convDone) begin
                  r_bcdValid <= 1'b1;
                  r_outState <= ST_RESULT;
                  r_state    <= S_HOLD;
                  if (!r_falseStart && !r_timeout && (r_elapsed < r_best)) begin
                     r_best <= r_elapsed;
                  end
               end
            end
            S_HOLD: begin
               r_outState <= ST_RESULT;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign go_led      = r_goLed;
   assign elapsed_ms  = r_elapsed;
   assign best_ms     = r_best;
   assign bcd         = w_convBcd;
   assign bcd_valid   = r_bcdValid;
   assign false_start = r_falseStart;
   assign timeout     = r_timeout;
   assign out_state   = r_outState;

endmodule

// File: tb/tb_reaction_measure.sv
// Self-checking bench for reaction_measure: randomized trials feed a scoreboard
// that a monitor drains whenever bcd_valid rises.
module tb_reaction_measure;

   localparam int CLK_HZ   = 1000;
   localparam int TICK_HZ  = 100;
   localparam int MAX_MS   = 50;
   localparam int DIV      = CLK_HZ / TICK_HZ;
   localparam int CONV_LAT = 15;
   localparam int FULL_CYC = MAX_MS * DIV;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        en    = 1'b0;
   logic [1:0]  KEY   = 2'b11;
   logic        go_led;
   logic [13:0] elapsed_ms;
   logic [13:0] best_ms;
   logic [15:0] bcd;
   logic        bcd_valid;
   logic        false_start;
   logic        timeout;
   logic [3:0]  out_state;

   typedef struct {
      int          elapsed;
      int          best;
      logic [15:0] bcd;
      bit          fs;
      bit          to;
      int          validCycle;
   } exp_t;

   exp_t        sbQ[$];
   exp_t        monE;
   int          cyc         = 0;
   int          vectors     = 0;
   int          miscompares = 0;
   int          bestModel   = MAX_MS;
   logic [15:0] lastBcd     = 16'h0000;
   logic        prevValid   = 1'b0;

   reaction_measure #(
      .CLK_HZ  (CLK_HZ),
      .TICK_HZ (TICK_HZ),
      .MAX_MS  (MAX_MS)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .KEY         (KEY),
      .go_led      (go_led),
      .elapsed_ms  (elapsed_ms),
      .best_ms     (best_ms),
      .bcd         (bcd),
      .bcd_valid   (bcd_valid),
      .false_start (false_start),
      .timeout     (timeout),
      .out_state   (out_state)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] toBcd(input int v);
      return 16'(((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10));
   endfunction

   task automatic checkOutput(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic checkResetValues();
      checkOutput("reset go_led", int'(go_led), 0);
      checkOutput("reset elapsed_ms", int'(elapsed_ms), 0);
      checkOutput("reset best_ms", int'(best_ms), MAX_MS);
      checkOutput("reset bcd", int'(bcd), 0);
      checkOutput("reset bcd_valid", int'(bcd_valid), 0);
      checkOutput("reset false_start", int'(false_start), 0);
      checkOutput("reset timeout", int'(timeout), 0);
      checkOutput("reset out_state", int'(out_state), 1);
   endtask

   // Monitor: every rising bcd_valid must match the oldest expected result.
   always @(negedge clk) begin
      if (bcd_valid && !prevValid) begin
         if (sbQ.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpected result: bcd_valid rose at cycle %0d with nothing expected", cyc);
         end else begin
            monE = sbQ.pop_front();
            checkOutput("result cycle", cyc, monE.validCycle);
            checkOutput("elapsed_ms", int'(elapsed_ms), monE.elapsed);
            checkOutput("bcd", int'(bcd), int'(monE.bcd));
            checkOutput("best_ms", int'(best_ms), monE.best);
            checkOutput("false_start", int'(false_start), int'(monE.fs));
            checkOutput("timeout", int'(timeout), int'(monE.to));
            checkOutput("out_state at result", int'(out_state), 3);
            checkOutput("go_led at result", int'(go_led), 0);
         end
      end
      prevValid = bcd_valid;
   end

   // kind 0: press d cycles after COUNT entry; 1: false start; 2: no press at all.
   task automatic applyStimulus(input int kind, input int d);
      exp_t e;
      int   c;
      int   f;
      int   waitCnt;
      en     = 1'b0;
      KEY[1] = (kind == 1) ? 1'b0 : 1'b1;
      repeat (5) @(posedge clk);
      #1;
      c  = cyc;
      en = 1'b1;
      if (kind == 1) begin
         f = 0; e.elapsed = 0; e.fs = 1'b1; e.to = 1'b0;
      end else if (kind == 0 && d + 3 <= FULL_CYC) begin
         f = d + 3; e.elapsed = (d + 2) / DIV; e.fs = 1'b0; e.to = 1'b0;
      end else begin
         f = FULL_CYC; e.elapsed = MAX_MS; e.fs = 1'b0; e.to = 1'b1;
      end
      if (!e.fs && !e.to && e.elapsed < bestModel) bestModel = e.elapsed;
      e.best       = bestModel;
      e.bcd        = toBcd(e.elapsed);
      e.validCycle = c + 1 + f + CONV_LAT;
      lastBcd      = e.bcd;
      sbQ.push_back(e);
      if (kind == 0) begin
         repeat (d + 1) @(posedge clk);
         #1;
         if (d < FULL_CYC) checkOutput("go_led while counting", int'(go_led), 1);
         KEY[1] = 1'b0;
      end
      waitCnt = 0;
      while (sbQ.size() != 0 && waitCnt < 800) begin
         @(posedge clk);
         waitCnt++;
      end
      if (sbQ.size() != 0) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL result wait: no bcd_valid within 800 cycles, got none, expected one");
         sbQ.delete();
      end
      repeat (2) @(posedge clk);
      #1;
      checkOutput("out_state in HOLD", int'(out_state), 3);
      en     = 1'b0;
      KEY[1] = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("out_state after en low", int'(out_state), 1);
   endtask

   task automatic resetMidCount();
      en     = 1'b0;
      KEY[1] = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      en = 1'b1;
      repeat (60) @(posedge clk);
      #1;
      checkOutput("mid-count go_led", int'(go_led), 1);
      checkOutput("mid-count elapsed_ms", int'(elapsed_ms), 5);
      #2;
      rst_n = 1'b0;
      #1;
      checkResetValues();
      en        = 1'b0;
      bestModel = MAX_MS;
      lastBcd   = 16'h0000;
      sbQ.delete();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic applyAbort(input int d);
      en     = 1'b0;
      KEY[1] = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      en = 1'b1;
      repeat (d + 1) @(posedge clk);
      #1;
      KEY[1] = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      en = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("abort bcd_valid", int'(bcd_valid), 0);
      checkOutput("abort out_state", int'(out_state), 1);
      checkOutput("abort elapsed_ms", int'(elapsed_ms), (d + 2) / DIV);
      checkOutput("abort go_led", int'(go_led), 0);
      repeat (20) @(posedge clk);
      #1;
      checkOutput("abort bcd retained", int'(bcd), int'(lastBcd));
      checkOutput("abort bcd_valid later", int'(bcd_valid), 0);
      checkOutput("abort best_ms", int'(best_ms), bestModel);
      KEY[1] = 1'b1;
   endtask

   initial begin
      int r;
      int kind;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkResetValues();
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus(0, 123);
      applyStimulus(1, 0);
      applyStimulus(2, 0);
      applyStimulus(0, 497);
      applyStimulus(0, 498);

      resetMidCount();
      applyStimulus(0, 198);
      applyStimulus(0, 298);
      applyStimulus(0, 68);
      applyAbort(30);

      for (int i = 0; i < 12; i++) begin
         r    = int'($urandom_range(0, 99));
         kind = (r < 70) ? 0 : ((r < 85) ? 1 : 2);
         applyStimulus(kind, int'($urandom_range(0, 520)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/reaction_measure.md
# reaction_measure

Measures the player's reaction time once the random delay in the reaction timer has expired. It is enabled by the top-level state sequencer on the "go" state and counts milliseconds until KEY[1] is pressed. It then reports the elapsed time in binary and in 4-digit BCD for the HEX displays, and keeps a best-time register. It flags false starts and timeouts, and requests the next top-level state over the shared `out_state` encoding.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000: input clock frequency.
- `TICK_HZ`, 1000: count rate; `DIV = CLK_HZ/TICK_HZ` must be ≥ 2.
- `MAX_MS`, 9999: saturation / timeout value; must fit in 14 bits.

Ports:
- `clk` in 1: system clock; all state on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: high while the sequencer is in the measure state.
- `KEY` in 2: raw active-low push buttons. Only KEY[1] is used.
- `go_led` out 1: high while counting.
- `elapsed_ms` out 14: current or frozen reaction time.
- `best_ms` out 14: lowest valid time since reset.
- `bcd` out 16: 4 BCD digits of `elapsed_ms`, thousands digit in [15:12].
- `bcd_valid` out 1: `bcd` matches the frozen `elapsed_ms`.
- `false_start` out 1: KEY[1] was already down when counting began.
- `timeout` out 1: `MAX_MS` was reached without a press.
- `out_state` out 4: next-state request. 1 = WAIT, 2 = MEASURE, 3 = RESULT.

## Operation
- Input conditioning:
  - KEY[1] passes through a 2-flop synchronizer; `press` is its synchronized low level.
  - `press_edge` is a synchronized high→low transition.
- Tick counter:
  - Counts 0..DIV-1; emits `tick` on the DIV-1 cycle.
  - Cleared when entering COUNT.
- FSM states: IDLE, COUNT, CONVERT, HOLD.
- IDLE:
  - Outputs hold their last values.
  - When `en` = 1: clear `elapsed_ms`, `bcd_valid`, `false_start`, `timeout`.
  - If `press` = 1 in that same cycle: set `false_start` and go to CONVERT. `elapsed_ms` stays 0.
  - Otherwise go to COUNT.
- COUNT:
  - `go_led` = 1.
  - On `tick`: `elapsed_ms`+1.
  - On `press_edge`: freeze `elapsed_ms` and go to CONVERT. A tick in the same cycle is not applied.
  - When `elapsed_ms` reaches `MAX_MS`: set `timeout` and go to CONVERT.
  - Press wins over timeout if both occur in the same cycle.
- CONVERT:
  - Sequential double-dabble conversion of `elapsed_ms`: 14 shift cycles, then load `bcd` and set `bcd_valid`.
  - On a valid result (no false start, no timeout) with `elapsed_ms` < `best_ms`: update `best_ms`.
  - Then go to HOLD.
- HOLD: wait for `en` = 0, then go to IDLE.
- `en` falling in any state: go to IDLE on the next edge. If a conversion is aborted, `bcd_valid` stays 0; `elapsed_ms` is retained.
- `out_state`:
  - 1 when `en` = 0.
  - 2 in IDLE/COUNT/CONVERT with `en` = 1.
  - 3 in HOLD.
- Widths: `elapsed_ms` and `best_ms` are unsigned 14-bit. `MAX_MS` ≤ 9999, so no BCD overflow.

## Timing
- Reset values:
  - FSM = IDLE; `go_led` = 0; `elapsed_ms` = 0; `best_ms` = `MAX_MS`.
  - `bcd` = 0; `bcd_valid` = 0; `false_start` = 0; `timeout` = 0.
  - `out_state` = 1; tick counter = 0; synchronizer flops = 1 (released).
- `en` rising → COUNT one edge later. The first increment comes exactly DIV cycles after COUNT entry.
- Press latency: a KEY[1] low edge freezes the count 3 cycles later (2 sync + edge).
- CONVERT lasts 15 cycles: `bcd_valid` rises 15 cycles after leaving COUNT, and HOLD is entered on the same edge.
- `rst_n` low at any time forces reset values immediately, regardless of `clk`.

## Structure
- Shared package `reaction_pkg`:
  - State codes ST_WAIT=1, ST_MEASURE=2, ST_RESULT=3.
  - `MS_W`=14, `BCD_W`=16.
  - The FSM enum.
- Sub-module `bin2bcd_seq`:
  - Start/busy/done handshake.
  - 14-bit in, 16-bit out, 15-cycle latency.
  - Also reusable for displaying `best_ms`.
- Tick divider and synchronizer are inline.

## Test plan
Bench parameters: `CLK_HZ`=1000, `TICK_HZ`=100 (DIV=10), `MAX_MS`=50.
- Reset mid-COUNT: assert `rst_n`=0 asynchronously → every output returns to its reset value immediately; `best_ms`=50.
- Valid press: raise `en`, drop KEY[1] at cycle 123 after COUNT entry → `elapsed_ms`=12, `bcd`=16'h0012, `bcd_valid` high 15 cycles after the freeze, `best_ms`=12, `out_state`=3.
- False start: KEY[1] held low before `en` rises → `false_start`=1, `elapsed_ms`=0, `best_ms` unchanged, `out_state` ends at 3.
- Timeout: no press → `elapsed_ms`=50 after 500 cycles, `timeout`=1, `bcd`=16'h0050, `best_ms` unchanged.
- Best tracking: runs of 20 then 30 → `best_ms` stays 20; a following run of 7 → `best_ms`=7.
- `en` abort: drop `en` during CONVERT → IDLE next edge, `bcd_valid`=0, `out_state`=1, `elapsed_ms` retained.
